// File: rtl/coef_ram_iomem_target.sv
// coef_ram_iomem_target: iomem target for the DSP coefficient/program RAM with engine read port and write lock.
// Optional feature macro: COEF_RAM_READBACK_EN (CPU reads of RAM words return stored data; otherwise 0).
module coef_ram_iomem_target #(
    parameter logic [7:0] BASE_ADDR = 8'h60,
    parameter int         ADDR_W    = 6
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    input  logic [ADDR_W-1:0] eng_addr,
    output logic [31:0]       eng_rdata,
    input  logic              lock
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] a_word;
    logic              a_status;
    logic [3:0]        a_wstrb;
    logic [31:0]       a_wdata;
    logic [31:0]       rd_q;
    logic [15:0]       err_cnt;
    logic [31:0]       ram [2**ADDR_W];
    logic [31:0]       ram_rd;
    logic              hit;
    logic              ram_wr;
    logic              unused_addr;

    assign hit         = iomem_valid && iomem_addr[31:24] == BASE_ADDR;
    assign ram_wr      = state == ACCESS && !a_status && a_wstrb != 4'h0;
    assign unused_addr = ^{iomem_addr[22:ADDR_W+2], iomem_addr[1:0]};

`ifdef COEF_RAM_READBACK_EN
    assign ram_rd = ram[a_word];
`else
    assign ram_rd = 32'h0;
`endif

    // Transaction FSM: latch request, access, one-cycle ready pulse, then wait for valid to drop
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            rd_q        <= 32'h0;
            err_cnt     <= 16'h0;
            a_word      <= '0;
            a_status    <= 1'b0;
            a_wstrb     <= 4'h0;
            a_wdata     <= 32'h0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    a_word   <= iomem_addr[ADDR_W+1:2];
                    a_status <= iomem_addr[23];
                    a_wstrb  <= iomem_wstrb;
                    a_wdata  <= iomem_wdata;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    rd_q <= (a_wstrb != 4'h0) ? 32'h0 : a_status ? {15'h0, lock, err_cnt} : ram_rd;
                    if (a_status && a_wstrb != 4'h0)
                        err_cnt <= 16'h0;
                    else if (ram_wr && lock && err_cnt != 16'hFFFF)
                        err_cnt <= err_cnt + 16'd1;
                    state <= RESP;
                end
                RESP: begin
                    iomem_ready <= 1'b1;
                    iomem_rdata <= rd_q;
                    state       <= HOLD;
                end
                HOLD: begin
                    iomem_ready <= 1'b0;
                    iomem_rdata <= 32'h0;
                    if (!iomem_valid) state <= IDLE;
                end
            endcase
        end
    end

    // CPU byte-lane writes, suppressed while the engine holds the lock
    always_ff @(posedge ck) begin
        if (ram_wr && !lock)
            for (int i = 0; i < 4; i++)
                if (a_wstrb[i]) ram[a_word][8*i +: 8] <= a_wdata[8*i +: 8];
    end

    // Engine read port: registered, read-before-write against a same-cycle CPU write
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) eng_rdata <= 32'h0;
        else      eng_rdata <= ram[eng_addr];
    end
endmodule

// File: tb/tb_coef_ram_iomem_target.sv
// tb_coef_ram_iomem_target: directed vector bench for coef_ram_iomem_target.
`ifdef COEF_RAM_READBACK_EN
`define TB_RB(x) (x)
`else
`define TB_RB(x) 32'h0
`endif
module tb_coef_ram_iomem_target;
    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [5:0]  eng_addr = 6'h0;
    logic [31:0] eng_rdata;
    logic        lock = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    coef_ram_iomem_target dut (
        .ck(ck), .rst(rst), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .eng_addr(eng_addr), .eng_rdata(eng_rdata), .lock(lock)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lk;
        logic [5:0]  ea;
        logic [31:0] exp_rdata;
        logic [31:0] exp_eng;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called on a negedge; returns on the negedge after the ready pulse
    task automatic xfer(input logic [3:0] ws, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
        int n;
        n = 0;
        iomem_valid = 1'b1;
        iomem_wstrb = ws;
        iomem_addr  = a;
        iomem_wdata = wd;
        @(posedge ck);
        while (n < 20) begin
            @(negedge ck);
            n++;
            if (iomem_ready) break;
        end
        rd = iomem_rdata;
        chk("latency", n, 3);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge ck);
        chk("ready_pulse", {31'h0, iomem_ready}, 32'h0);
        chk("idle_rdata", iomem_rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int bad;
        vt[0]  = '{4'h0, 32'h6080_0000, 32'h0,         1'b0, 6'd0, 32'h0,                 32'h0};
        vt[1]  = '{4'hF, 32'h6000_0000, 32'h8404_2000, 1'b0, 6'd0, 32'h0,                 32'h8404_2000};
        vt[2]  = '{4'h0, 32'h6000_0000, 32'hFFFF_FFFF, 1'b0, 6'd0, `TB_RB(32'h8404_2000), 32'h8404_2000};
        vt[3]  = '{4'hF, 32'h6000_0004, 32'h1122_3344, 1'b0, 6'd1, 32'h0,                 32'h1122_3344};
        vt[4]  = '{4'h2, 32'h6000_0004, 32'h0000_AA00, 1'b0, 6'd1, 32'h0,                 32'h1122_AA44};
        vt[5]  = '{4'h0, 32'h6000_0004, 32'h0,         1'b0, 6'd1, `TB_RB(32'h1122_AA44), 32'h1122_AA44};
        vt[6]  = '{4'hF, 32'h6000_0008, 32'hFE00_0000, 1'b0, 6'd2, 32'h0,                 32'hFE00_0000};
        vt[7]  = '{4'hF, 32'h6000_0008, 32'hDEAD_BEEF, 1'b1, 6'd2, 32'h0,                 32'hFE00_0000};
        vt[8]  = '{4'h0, 32'h6080_0000, 32'h0,         1'b1, 6'd2, 32'h0001_0001,         32'hFE00_0000};
        vt[9]  = '{4'h1, 32'h6080_0000, 32'h1234_5678, 1'b0, 6'd2, 32'h0,                 32'hFE00_0000};
        vt[10] = '{4'h0, 32'h6080_0000, 32'h0,         1'b0, 6'd2, 32'h0,                 32'hFE00_0000};
        vt[11] = '{4'hF, 32'h6040_0104, 32'hCAFE_0001, 1'b0, 6'd1, 32'h0,                 32'hCAFE_0001};
        vt[12] = '{4'h8, 32'h6000_0000, 32'h7700_0000, 1'b0, 6'd0, 32'h0,                 32'h7704_2000};
        vt[13] = '{4'hF, 32'h6000_0000, 32'hFFFF_FFFF, 1'b1, 6'd0, 32'h0,                 32'h7704_2000};
        vt[14] = '{4'h0, 32'h6080_0000, 32'h0,         1'b0, 6'd0, 32'h0000_0001,         32'h7704_2000};

        #12;
        chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_eng", eng_rdata, 32'h0);
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);

        for (int i = 0; i < 15; i++) begin
            lock = vt[i].lk;
            xfer(vt[i].wstrb, vt[i].addr, vt[i].wdata, rd);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
            eng_addr = vt[i].ea;
            @(negedge ck);
            chk($sformatf("v%0d_eng", i), eng_rdata, vt[i].exp_eng);
        end
        lock = 1'b0;

        // same-cycle CPU write and engine read of word 2 returns the old data
        eng_addr    = 6'd2;
        iomem_valid = 1'b1;
        iomem_wstrb = 4'hF;
        iomem_addr  = 32'h6000_0008;
        iomem_wdata = 32'h1234_5678;
        @(posedge ck);
        @(negedge ck);
        chk("rbw_before", eng_rdata, 32'hFE00_0000);
        @(negedge ck);
        chk("rbw_same_cycle", eng_rdata, 32'hFE00_0000);
        @(negedge ck);
        chk("rbw_ready", {31'h0, iomem_ready}, 32'h1);
        chk("rbw_after", eng_rdata, 32'h1234_5678);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge ck);

        // request to another target's window is ignored
        iomem_valid = 1'b1;
        iomem_addr  = 32'h6200_0000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ck);
            if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) bad++;
        end
        chk("miss_quiet", bad, 0);
        iomem_valid = 1'b0;
        @(negedge ck);

        // valid held after ready: no second acknowledge until it drops
        iomem_valid = 1'b1;
        iomem_addr  = 32'h6080_0000;
        @(posedge ck);
        @(negedge ck);
        @(negedge ck);
        @(negedge ck);
        chk("hold_ready", {31'h0, iomem_ready}, 32'h1);
        chk("hold_rdata", iomem_rdata, 32'h0000_0001);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ck);
            if (iomem_ready !== 1'b0) bad++;
        end
        chk("hold_no_second", bad, 0);
        iomem_valid = 1'b0;
        @(negedge ck);
        xfer(4'h0, 32'h6000_0008, 32'h0, rd);
        chk("hold_next_rdata", rd, `TB_RB(32'h1234_5678));

        // reset during ACCESS of a write drops the write
        xfer(4'hF, 32'h6000_000C, 32'h5555_5555, rd);
        eng_addr    = 6'd3;
        iomem_valid = 1'b1;
        iomem_wstrb = 4'hF;
        iomem_addr  = 32'h6000_000C;
        iomem_wdata = 32'hAAAA_AAAA;
        @(posedge ck);
        #1 rst = 1'b0;
        #1;
        chk("arst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("arst_rdata", iomem_rdata, 32'h0);
        chk("arst_eng", eng_rdata, 32'h0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge ck);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            if (iomem_ready !== 1'b0) bad++;
        end
        chk("arst_no_ready", bad, 0);
        chk("arst_word_kept", eng_rdata, 32'h5555_5555);
        xfer(4'h0, 32'h6080_0000, 32'h0, rd);
        chk("arst_err_cleared", rd, 32'h0);

        // reset during the ready pulse clears it immediately
        lock        = 1'b1;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h6080_0000;
        @(posedge ck);
        @(negedge ck);
        @(negedge ck);
        @(negedge ck);
        chk("rst2_ready_before", {31'h0, iomem_ready}, 32'h1);
        chk("rst2_rdata_before", iomem_rdata, 32'h0001_0000);
        #1 rst = 1'b0;
        #1;
        chk("rst2_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst2_rdata", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
